// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: DEPTH-entry circular buffer with a valid/ready
// handshake, synchronous flush and a saturating count of flushed entries.
module pipe_stage_elastic #(
    parameter int WIDTH    = 72,
    parameter int DEPTH    = 2,
    parameter int AFULL_TH = DEPTH - 1,
    parameter int CNTW     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full,
    output logic [CNTW-1:0]        drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = ((CNTW > CW) ? CNTW : CW) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [SW-1:0] DROP_MAX = SW'({CNTW{1'b1}});

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             push;
    logic             pop;

    // Sum is formed wide enough that neither operand can wrap before clamping.
    function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] acc,
                                                input logic [CW-1:0]   inc);
        logic [SW-1:0] sum;
        sum = SW'(acc) + SW'(inc);
        return (sum > DROP_MAX) ? {CNTW{1'b1}} : sum[CNTW-1:0];
    endfunction

    assign in_ready    = (count < DEPTH_C);
    assign out_valid   = (count != '0);
    assign almost_full = (count >= AFULL_C);
    assign push        = in_valid & in_ready & ~flush;
    assign pop         = out_valid & out_ready & ~flush;
    assign out_data    = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            // An empty buffer has nothing to discard, so leave everything as is.
            if (count != '0) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                drop_cnt <= sat_add(drop_cnt, count);
            end
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Payload storage carries no reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

`ifndef SYNTHESIS
    count_in_range: assert property (@(posedge clk) disable iff (reset)
        count <= DEPTH_C);

    head_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Randomised and directed bench for pipe_stage_elastic; a queue-based reference
// model predicts occupancy, head data and drop statistics.
module tb_pipe_stage_elastic;
    localparam int WIDTH    = 8;
    localparam int DEPTH    = 4;
    localparam int AFULL_TH = 3;
    localparam int CNTW     = 4;
    localparam int DROP_SAT = (1 << CNTW) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       count;
    logic             almost_full;
    logic [CNTW-1:0]  drop_cnt;

    logic [WIDTH-1:0] exp_q[$];
    int               drop_m;
    int               vectors;
    int               n_checks;
    int               miscompares;

    pipe_stage_elastic #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .CNTW(CNTW)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .almost_full(almost_full), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every observable output against the model's view of the buffer.
    task automatic check_state(input string tag);
        int n;
        logic [WIDTH-1:0] head;
        n    = exp_q.size();
        head = (n != 0) ? exp_q[0] : '0;
        chk({tag, "_count"},       32'(count),       32'(n));
        chk({tag, "_in_ready"},    32'(in_ready),    32'(n < DEPTH));
        chk({tag, "_out_valid"},   32'(out_valid),   32'(n != 0));
        chk({tag, "_almost_full"}, 32'(almost_full), 32'(n >= AFULL_TH));
        chk({tag, "_out_data"},    32'(out_data),    32'(head));
        chk({tag, "_drop_cnt"},    32'(drop_cnt),    32'(drop_m));
    endtask

    // Monitor: samples mid-cycle, pops the scoreboard on every real handshake.
    always begin
        logic [WIDTH-1:0] e;
        @(negedge clk);
        #2;
        check_state("mon");
        if (out_valid && out_ready && !flush && !reset) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                miscompares++;
                $display("FAIL unexpected_output: got %0h expected none at %0t", out_data, $time);
            end else begin
                e = exp_q.pop_front();
                chk("pop_data", 32'(out_data), 32'(e));
            end
        end
    end

    // One clock of stimulus; the model is updated just after the edge it describes.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic rdy, input logic fl);
        bit acc;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        flush     = fl;
        acc       = v && !fl && (exp_q.size() < DEPTH);
        vectors++;
        @(posedge clk);
        #1;
        if (fl) begin
            drop_m = drop_m + exp_q.size();
            if (drop_m > DROP_SAT) drop_m = DROP_SAT;
            exp_q.delete();
        end else if (acc) begin
            exp_q.push_back(d);
        end
    endtask

    int sat_exp[5] = '{4, 8, 12, 15, 15};

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        drop_m = 0; vectors = 0; n_checks = 0; miscompares = 0;
        #1;
        check_state("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Streaming: each value must be head exactly one cycle after its push.
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Back-pressure fill, ignored push when full, ordered drain, then wrap.
        for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'(4));
        step(1'b1, 8'hA4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 8'hB0 + 8'(i), 1'(i % 2), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Simultaneous push and pop at count 2.
        step(1'b1, 8'hC0, 1'b0, 1'b0);
        step(1'b1, 8'hC1, 1'b0, 1'b0);
        step(1'b1, 8'hC2, 1'b1, 1'b0);
        chk("pushpop_count", 32'(count), 32'(2));
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Flush with three held entries and a concurrent push.
        for (int i = 0; i < 3; i++) step(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b1);
        chk("flush_drop", 32'(drop_cnt), 32'(3));
        step(1'b0, '0, 1'b1, 1'b1);
        chk("flush_empty_drop", 32'(drop_cnt), 32'(3));
        step(1'b0, '0, 1'b1, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0));

        // Asynchronous reset mid-cycle with two entries held.
        step(1'b1, 8'hE0, 1'b0, 1'b0);
        step(1'b1, 8'hE1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #3;
        reset = 1'b1;
        exp_q.delete();
        drop_m = 0;
        #1;
        check_state("async_rst");
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 8'h7E, 1'b0, 1'b0);
        chk("post_rst_count", 32'(count), 32'(1));
        chk("post_rst_data", 32'(out_data), 32'(8'h7E));
        step(1'b0, '0, 1'b1, 1'b0);

        // Saturating drop counter over repeated full flushes.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) step(1'b1, 8'(16 * k + i), 1'b0, 1'b0);
            step(1'b0, '0, 1'b0, 1'b1);
            chk("drop_sat", 32'(drop_cnt), 32'(sat_exp[k]));
        end

        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised elastic pipeline register. It is the next-generation replacement for the fixed single-entry stall/flush stage registers between IF/ID/EX/MEM/WB.
- Adds a valid/ready handshake, a DEPTH-entry buffer that absorbs back-pressure without bubbles, a synchronous flush that discards in-flight entries, and occupancy/drop statistics.
- Sits between any two CPU pipeline stages. It also serves as a decoupling buffer on the inst/data SRAM response paths.

Parameters:
- WIDTH, 72, payload width in bits (1..256).
- DEPTH, 2, buffer entries; power of two, 2..16.
- AFULL_TH, DEPTH-1, occupancy at or above which almost_full asserts (1..DEPTH).
- CNTW, 16, width of drop_cnt.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all held entries and of any same-cycle push.
- in_valid  in  1  upstream holds a valid payload.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes head this cycle.
- out_data  out  WIDTH  head payload; forced to 0 when out_valid=0.
- count  out  $clog2(DEPTH)+1  current occupancy.
- almost_full  out  1  count >= AFULL_TH.
- drop_cnt  out  CNTW  saturating total of valid entries discarded by flush.

Behaviour:
- Reset is asynchronous, active-high: reset on clk, asynchronous, active-high. During and after reset:
  - count=0, out_valid=0, out_data=0, in_ready=1, almost_full=0, drop_cnt=0.
  - Read and write pointers = 0; storage contents are don't-care.
- Handshake definitions:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
  - Once out_valid=1, it stays 1 with out_data stable until pop or flush.
- in_ready = (count < DEPTH). It is registered-state only, with no combinational path from out_ready. When full, a pop does not free a slot until the next cycle.
- Latency: a payload pushed in cycle N appears at out_valid/out_data in cycle N+1. There is no combinational in-to-out bypass.
- Storage is a circular buffer:
  - Write pointer advances on push, read pointer advances on pop.
  - Both pointers are modulo DEPTH and wrap from DEPTH-1 to 0.
  - out_data = mem[rd_ptr] masked by out_valid.
- Count update: push only → +1; pop only → -1; push and pop together → unchanged, with the head advancing and the new entry written at the tail.
- Empty with push and out_ready=1 in the same cycle: no pop, because out_valid=0. The entry appears next cycle.
- Flush has the highest priority over push and pop:
  - Next cycle: count=0, pointers=0, out_valid=0.
  - A same-cycle push is discarded and not counted as dropped.
  - drop_cnt += count (pre-flush value), saturating at 2^CNTW-1.
- flush while empty: state is unchanged and drop_cnt is unchanged.
- reset asserted mid-transfer: state clears immediately and asynchronously. The first post-reset push behaves as from empty.
- almost_full is combinational from count.
- in_valid may drop without a handshake. The stage imposes no stickiness rule on the upstream side.
- Simulation assertions: count never exceeds DEPTH or underflows; out_data is stable while out_valid & ~out_ready & ~flush.

Test Plan:
- Streaming (DEPTH=2, WIDTH=8): push 0x01..0x10 on consecutive cycles with out_ready=1 → each value appears on out_data exactly one cycle after its push. No bubbles, count stays ≤1, in_ready stays 1.
- Back-pressure fill and wrap (DEPTH=4): hold out_ready=0 and push 0xA0..0xA3 → count=4, in_ready=0, almost_full=1 (AFULL_TH=3), and a push attempt of 0xA4 is ignored. Then release out_ready → 0xA0..0xA3 drain in order. Follow with six more pushes to exercise pointer wrap; order is preserved.
- Simultaneous push/pop at count=2 → count stays 2, the head advances to the next entry, and the new tail value emerges after the two older entries.
- Flush with 3 entries held plus a concurrent push of 0x55 → next cycle count=0, out_valid=0, out_data=0, drop_cnt=3, and 0x55 never emerges. A second flush while empty leaves drop_cnt=3.
- drop_cnt saturation (CNTW=4): repeated flushes of full DEPTH=4 buffers → drop_cnt reads 4, 8, 12, 15, 15.
- Asynchronous reset asserted mid-cycle with 2 entries held and out_ready=0 → outputs clear before the next clk edge. After deassertion, push 0x7E appears one cycle later with count=1.
